// File: rtl/stack_pgm_encoder.sv
// rtl/stack_pgm_encoder.sv - encodes symbolic stack-CPU commands into program memory words
//
// Accepts commands (opcode + operand) over a valid/ready handshake, encodes each
// into a 16-bit word {opcode, imm11}, writes the words to program memory from
// address 0 and terminates every program with HALT_CPU (0xF800).
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake
//   cmd_opcode, cmd_imm   command opcode and operand (operand used by PUSH only)
//   cmd_last              final command of the program
//   load_start            pulse in DONE to begin a new program
//   mem_we/addr/wdata     program memory write port (registered)
//   load_done             program complete, HALT written
//   instr_count           words written, including HALT
//   err_range/opcode/full sticky error flags
//   checksum              running XOR of written words (STACK_ENC_CHECKSUM_EN only)
//
// Optional feature macro: STACK_ENC_CHECKSUM_EN

module stack_pgm_encoder #(
  parameter int DATA_WIDTH     = 32,
  parameter int INSTR_WIDTH    = 16,
  parameter int PGRM_MEM_DEPTH = 256,
  parameter int PC_WIDTH       = $clog2(PGRM_MEM_DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [4:0]             cmd_opcode,
  input  logic [DATA_WIDTH-1:0]  cmd_imm,
  input  logic                   cmd_last,
  input  logic                   load_start,
  output logic                   mem_we,
  output logic [PC_WIDTH-1:0]    mem_addr,
  output logic [INSTR_WIDTH-1:0] mem_wdata,
  output logic                   load_done,
  output logic [PC_WIDTH:0]      instr_count,
  output logic                   err_range,
  output logic                   err_opcode,
  output logic                   err_full
`ifdef STACK_ENC_CHECKSUM_EN
  ,
  output logic [15:0]            checksum
`endif
);

  localparam logic [4:0] OP_PUSH   = 5'd0;
  localparam logic [4:0] OP_ADD    = 5'd1;
  localparam logic [4:0] OP_SUB    = 5'd2;
  localparam logic [4:0] OP_MUL    = 5'd3;
  localparam logic [4:0] OP_DIV    = 5'd4;
  localparam logic [4:0] OP_MOD    = 5'd5;
  localparam logic [4:0] OP_AND    = 5'd6;
  localparam logic [4:0] OP_OR     = 5'd7;
  localparam logic [4:0] OP_INVERT = 5'd8;
  localparam logic [4:0] OP_HALT   = 5'd31;

  localparam logic [PC_WIDTH:0]    LAST_SLOT = (PC_WIDTH+1)'(PGRM_MEM_DEPTH - 1);
  localparam logic [INSTR_WIDTH-1:0] HALT_WORD = INSTR_WIDTH'({OP_HALT, 11'd0});

  typedef enum logic [1:0] {S_LOAD, S_HALTW, S_DONE} state_t;

  state_t                 state;
  logic [PC_WIDTH:0]      wr_ptr;
  logic                   we_q;
  logic                   op_legal;
  logic                   imm_ok;
  logic                   do_write;
  logic [INSTR_WIDTH-1:0] enc_word;

  // Last slot is always kept free for the terminating HALT.
  assign cmd_ready   = (state == S_LOAD) && (wr_ptr < LAST_SLOT);
  assign instr_count = wr_ptr;
  // A write still in flight when reset arrives must not reach memory.
  assign mem_we      = we_q && !reset;

  always_comb begin
    op_legal = 1'b0;
    case (cmd_opcode)
      OP_PUSH, OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD,
      OP_AND, OP_OR, OP_INVERT, OP_HALT: op_legal = 1'b1;
      default:                           op_legal = 1'b0;
    endcase
    // Operand fits signed 11 bits when everything above bit 9 is sign extension.
    imm_ok   = (&cmd_imm[DATA_WIDTH-1:10]) || !(|cmd_imm[DATA_WIDTH-1:10]);
    do_write = op_legal && ((cmd_opcode != OP_PUSH) || imm_ok);
    enc_word = INSTR_WIDTH'({cmd_opcode, (cmd_opcode == OP_PUSH) ? cmd_imm[10:0] : 11'd0});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_LOAD;
      wr_ptr     <= '0;
      we_q       <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      load_done  <= 1'b0;
      err_range  <= 1'b0;
      err_opcode <= 1'b0;
      err_full   <= 1'b0;
`ifdef STACK_ENC_CHECKSUM_EN
      checksum   <= '0;
`endif
    end else begin
      we_q <= 1'b0;
      case (state)
        S_LOAD: begin
          if (cmd_valid && cmd_ready) begin
            if (!op_legal)
              err_opcode <= 1'b1;
            else if (cmd_opcode == OP_PUSH && !imm_ok)
              err_range <= 1'b1;
            if (do_write) begin
              we_q      <= 1'b1;
              mem_addr  <= wr_ptr[PC_WIDTH-1:0];
              mem_wdata <= enc_word;
              wr_ptr    <= wr_ptr + 1'b1;
`ifdef STACK_ENC_CHECKSUM_EN
              checksum  <= checksum ^ 16'(enc_word);
`endif
            end
            if (op_legal && cmd_opcode == OP_HALT) begin
              state     <= S_DONE;
              load_done <= 1'b1;
            end else if (cmd_last) begin
              state <= S_HALTW;
            end
          end else if (cmd_valid && wr_ptr >= LAST_SLOT) begin
            // Pending command is left unconsumed; program is truncated here.
            err_full <= 1'b1;
            state    <= S_HALTW;
          end
        end
        S_HALTW: begin
          we_q      <= 1'b1;
          mem_addr  <= wr_ptr[PC_WIDTH-1:0];
          mem_wdata <= HALT_WORD;
          wr_ptr    <= wr_ptr + 1'b1;
`ifdef STACK_ENC_CHECKSUM_EN
          checksum  <= checksum ^ 16'(HALT_WORD);
`endif
          load_done <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          if (load_start) begin
            wr_ptr     <= '0;
            load_done  <= 1'b0;
            err_range  <= 1'b0;
            err_opcode <= 1'b0;
            err_full   <= 1'b0;
`ifdef STACK_ENC_CHECKSUM_EN
            checksum   <= '0;
`endif
            state      <= S_LOAD;
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: doc/stack_pgm_encoder.md
Name: stack_pgm_encoder

Overview:
Program-side counterpart of the stack CPU instruction decoder. Accepts symbolic commands (opcode plus 32-bit operand) over a valid/ready handshake and encodes each into a 16-bit instruction word. Writes the words sequentially into program memory from address 0 and terminates every program with HALT_CPU. Sits between the testbench or host loader and the program memory write port.

Parameters:
DATA_WIDTH, 32 (DATA_WIDTH_DEF), width of cmd_imm
INSTR_WIDTH, 16 (INSTR_WIDTH_DEF), encoded instruction width
PGRM_MEM_DEPTH, 256 (PGRM_MEM_DEPTH_DEF), program memory words
PC_WIDTH, $clog2(PGRM_MEM_DEPTH), address width

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  encoder can accept a command
cmd_opcode  in  5  opcode_t value
cmd_imm  in  DATA_WIDTH  operand; used only for PUSH_IMMEDIATE
cmd_last  in  1  final command of program
load_start  in  1  one-cycle pulse; restarts loading from DONE
mem_we  out  1  program memory write strobe
mem_addr  out  PC_WIDTH  write address
mem_wdata  out  INSTR_WIDTH  encoded instruction
load_done  out  1  program complete, HALT written
instr_count  out  PC_WIDTH+1  words written, including HALT
err_range  out  1  sticky: PUSH operand out of range
err_opcode  out  1  sticky: undefined opcode
err_full  out  1  sticky: program truncated at memory end

Behaviour:
- Encoding: word[15:11] = opcode; word[10:0] = cmd_imm[10:0] for PUSH_IMMEDIATE, otherwise 0 (cmd_imm ignored).
- PUSH range: cmd_imm must be in signed 11-bit range −1024..1023, i.e. bits [31:10] all equal. Otherwise the command is consumed, nothing is written, and err_range is set.
- Legal opcodes: PUSH_IMMEDIATE, ADD, SUB, MUL, DIV, MOD, AND, OR, INVERT, HALT_CPU. Any other opcode is consumed, nothing is written, and err_opcode is set.
- A handshake occurs when cmd_valid && cmd_ready. The write happens one cycle later: mem_we is registered, and mem_addr/mem_wdata are valid with it. Throughput is 1 command/cycle.
- wr_ptr counts written words. It increments only for commands that are actually written and for the appended HALT. instr_count = wr_ptr.
- States:
  - LOAD: cmd_ready = (wr_ptr < PGRM_MEM_DEPTH−1); the last slot is reserved for HALT.
    - Accepted HALT_CPU: write it, go to DONE.
    - Accepted cmd_last with a legal non-HALT opcode: write it, go to HALTW.
    - Accepted cmd_last with an illegal or out-of-range command: no write, go to HALTW.
    - wr_ptr == PGRM_MEM_DEPTH−1 and cmd_valid high: err_full set, go to HALTW; the pending command is not consumed.
  - HALTW: cmd_ready = 0; write HALT_CPU (0xF800) at wr_ptr; go to DONE.
  - DONE: cmd_ready = 0; load_done = 1.
    - load_start: clear wr_ptr and all error flags, go to LOAD.
    - load_start outside DONE is ignored.
- Reset (any state, including mid-write): state = LOAD, wr_ptr = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, load_done = 0, all errors = 0, instr_count = 0. A write pending at reset is dropped.
- Error flags are sticky and do not stop loading.

Optional Feature:
STACK_ENC_CHECKSUM_EN:
- Defined: adds output checksum [15:0], the running XOR of every word written (including HALT). Cleared on reset and on load_start. Final value is valid when load_done = 1.
- Undefined: the port and logic are absent; behaviour is otherwise identical.

Test Plan:
- PUSH 5, PUSH −3, ADD (last) → writes addr 0..3 = 0x0005, 0x07FD, 0x0800, 0xF800; load_done; instr_count = 4.
- PUSH 1024, then MUL (last) → err_range = 1; addr0 = 0x1800, addr1 = 0xF800; instr_count = 2.
- Opcode 5'b10101, then HALT_CPU → err_opcode = 1; addr0 = 0xF800; no append; instr_count = 1.
- 300 back-to-back ADD with cmd_last never set → 255 ADD writes (0x0800), HALT at addr 255, err_full = 1, cmd_ready low from then on.
- Reset asserted the cycle after accepting PUSH 7 → mem_we = 0 next cycle, wr_ptr = 0; subsequent INVERT (last) writes 0x4000 at addr 0.
- From DONE, pulse load_start; load SUB (last) → errors cleared, addr0 = 0x1000, addr1 = 0xF800; with checksum enabled, checksum = 0xE800.
